tca9539_port_io: RTL

Pin-side I/O stage of the TCA9539 model, directly downstream of the I2C register interface: it consumes the output-value, polarity and configuration register bytes and drives the 16 port pins. It samples, synchronises and glitch-filters the pins, returns the polarity-corrected input value to the register interface as its readable input bytes, and generates the open-drain-style active-low interrupt with clear-on-read.

---
 rtl/tca9539_pkg.sv | 15 +
 rtl/tca9539_port_io_if.sv | 11 +
 rtl/tca9539_input_filter.sv | 33 +++
 rtl/tca9539_port_io.sv | 44 ++++
 4 files changed

// File: rtl/tca9539_pkg.sv
// tca9539_pkg: shared widths, filter default and register map of the TCA9539 model.
package tca9539_pkg;
  localparam int TCA_WIDTH        = 16;
  localparam int TCA_FILT_DEFAULT = 4;
  typedef enum logic [7:0] {
    TCA_REG_IN0  = 8'h00,
    TCA_REG_IN1  = 8'h01,
    TCA_REG_OUT0 = 8'h02,
    TCA_REG_OUT1 = 8'h03,
    TCA_REG_POL0 = 8'h04,
    TCA_REG_POL1 = 8'h05,
    TCA_REG_CFG0 = 8'h06,
    TCA_REG_CFG1 = 8'h07
  } tca_reg_e;
endpackage

// File: rtl/tca9539_port_io_if.sv
// tca9539_port_io_if: register-side bundle between the I2C register block and the pin stage.
interface tca9539_port_io_if import tca9539_pkg::*; #(parameter int WIDTH = TCA_WIDTH);
  logic [WIDTH-1:0] out_val;
  logic [WIDTH-1:0] polarity;
  logic [WIDTH-1:0] cfg;
  logic             rd_in;
  logic [WIDTH-1:0] input_val;
  logic             int_n;
  modport master (output out_val, polarity, cfg, rd_in, input input_val, int_n);
  modport slave  (input out_val, polarity, cfg, rd_in, output input_val, int_n);
endinterface

// File: rtl/tca9539_input_filter.sv
// tca9539_input_filter: one pin's two-flop synchroniser plus run-length glitch filter.
module tca9539_input_filter #(
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_filt
);
  localparam int CW = $clog2(FILT_CYCLES) + 1;
  logic          r_s1, r_s2, r_filt;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_CYCLES - 1)) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign o_filt = r_filt;
endmodule

// File: rtl/tca9539_port_io.sv
// tca9539_port_io: pin drive registers, filtered input readback and clear-on-read interrupt.
module tca9539_port_io import tca9539_pkg::*; #(
  parameter int WIDTH       = TCA_WIDTH,
  parameter int FILT_CYCLES = TCA_FILT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tca9539_port_io_if.slave       bus,
  input  logic [WIDTH-1:0]       i_pin_in,
  output logic [WIDTH-1:0]       o_pin_out,
  output logic [WIDTH-1:0]       o_pin_oe
);
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] r_snap, r_input_val, r_pin_out, r_pin_oe;
  logic             r_int_n;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tca9539_input_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_pin  (i_pin_in[i]),
      .o_filt (w_filt[i])
    );
  end
  // snapshot takes the pre-update filt, so an edge landing on a read cycle still interrupts next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin_out   <= '0;
      r_pin_oe    <= '0;
      r_input_val <= '0;
      r_snap      <= '0;
      r_int_n     <= 1'b1;
    end else begin
      r_pin_out   <= bus.out_val;
      r_pin_oe    <= ~bus.cfg;
      r_input_val <= w_filt ^ bus.polarity;
      r_snap      <= bus.rd_in ? w_filt : r_snap;
      r_int_n     <= bus.rd_in | ~|((w_filt ^ r_snap) & bus.cfg);
    end
  end
  assign o_pin_out     = r_pin_out;
  assign o_pin_oe      = r_pin_oe;
  assign bus.input_val = r_input_val;
  assign bus.int_n     = r_int_n;
endmodule
